// File: rtl/tehb_fifo.sv
// Transparent elastic FIFO: NUM_SLOTS-deep data buffer with zero-latency bypass when empty.
// ins_ready comes from registered occupancy only, so the ready chain is cut here.
module tehb_fifo #(
   parameter int DATA_TYPE = 32,
   parameter int NUM_SLOTS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_TYPE-1:0]           ins,
   input  logic                           ins_valid,
   output logic                           ins_ready,
   output logic [DATA_TYPE-1:0]           outs,
   output logic                           outs_valid,
   input  logic                           outs_ready,
   output logic [$clog2(NUM_SLOTS+1)-1:0] count
);

   localparam int CW = $clog2(NUM_SLOTS + 1);
   localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_SLOTS - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_SLOTS);

   logic [DATA_TYPE-1:0] mem [NUM_SLOTS];
   logic [PW-1:0]        head;
   logic [PW-1:0]        tail;
   logic [CW-1:0]        cnt;

   logic empty;
   logic full;
   logic enq;
   logic deq;

   // Depth need not be a power of two, so pointers wrap on an explicit compare.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == LAST_SLOT)
         n = '0;
      else
         n = p + 1'b1;
      return n;
   endfunction

   always_comb begin
      empty      = (cnt == '0);
      full       = (cnt == FULL_CNT);
      ins_ready  = ~full;
      outs_valid = ins_valid | ~empty;
      outs       = empty ? ins : mem[head];
      count      = cnt;
      // A bypassed token leaves in the same cycle, so it is never written.
      enq        = ins_valid & ~full & ~(empty & outs_ready);
      deq        = ~empty & outs_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (enq)
            tail <= next_ptr(tail);
         if (deq)
            head <= next_ptr(head);
         case ({enq, deq})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && enq)
         mem[tail] <= ins;
   end

   a_out_hold: assert property (@(posedge clk) disable iff (rst)
      (outs_valid && !outs_ready) |=> (outs_valid && $stable(outs)));

   a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
      cnt <= FULL_CNT);

   a_no_enq_full: assert property (@(posedge clk) disable iff (rst)
      full |-> !enq);

endmodule

// File: tb/tb_tehb_fifo.sv
// Self-checking bench for tehb_fifo: directed vector table on a 4-slot instance,
// then randomized traffic on a 3-slot instance checked against a queue model.
module tb_tehb_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_iv, a_ordy, a_irdy, a_ovalid;
   logic [31:0] a_ins, a_outs;
   logic [2:0]  a_count;

   logic        b_rst, b_iv, b_ordy, b_irdy, b_ovalid;
   logic [31:0] b_ins, b_outs;
   logic [1:0]  b_count;

   tehb_fifo #(.DATA_TYPE(32), .NUM_SLOTS(4)) dut4 (
      .clk(clk), .rst(a_rst), .ins(a_ins), .ins_valid(a_iv), .ins_ready(a_irdy),
      .outs(a_outs), .outs_valid(a_ovalid), .outs_ready(a_ordy), .count(a_count));

   tehb_fifo #(.DATA_TYPE(32), .NUM_SLOTS(3)) dut3 (
      .clk(clk), .rst(b_rst), .ins(b_ins), .ins_valid(b_iv), .ins_ready(b_irdy),
      .outs(b_outs), .outs_valid(b_ovalid), .outs_ready(b_ordy), .count(b_count));

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] ins;
      logic        ordy;
      logic        e_ready;
      logic        e_valid;
      logic [31:0] e_outs;
      logic [2:0]  e_count;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs[NV];

   int n_checks = 0;
   int n_fail   = 0;

   // Random-phase state
   int unsigned mq[$];
   int unsigned next_send;
   int unsigned next_recv;
   int          stored_enq;
   int          cycles;

   function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                               input logic o, input logic er, input logic ev,
                               input logic [31:0] eo, input logic [2:0] ec);
      vec_t v;
      v.rst = r; v.iv = iv; v.ins = d; v.ordy = o;
      v.e_ready = er; v.e_valid = ev; v.e_outs = eo; v.e_count = ec;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      a_rst  = v.rst;
      a_iv   = v.iv;
      a_ins  = v.ins;
      a_ordy = v.ordy;
      #1;
   endtask

   initial begin
      // 0: post-reset idle, outs mirrors ins combinationally
      vecs[0]  = mk(1'b0, 1'b0, 32'h55, 1'b0, 1'b1, 1'b0, 32'h55, 3'd0);
      // 1-3: streaming bypass
      vecs[1]  = mk(1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 3'd0);
      vecs[2]  = mk(1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 3'd0);
      vecs[3]  = mk(1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 3'd0);
      // 4-9: fill under back-pressure, 0xA4 held off when full
      vecs[4]  = mk(1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 32'hA0, 3'd0);
      vecs[5]  = mk(1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA0, 3'd1);
      vecs[6]  = mk(1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA0, 3'd2);
      vecs[7]  = mk(1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 32'hA0, 3'd3);
      vecs[8]  = mk(1'b0, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA0, 3'd4);
      vecs[9]  = mk(1'b0, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA0, 3'd4);
      // 10-15: drain from full; ready returns one cycle after the first dequeue
      vecs[10] = mk(1'b0, 1'b1, 32'hA4, 1'b1, 1'b0, 1'b1, 32'hA0, 3'd4);
      vecs[11] = mk(1'b0, 1'b1, 32'hA4, 1'b1, 1'b1, 1'b1, 32'hA1, 3'd3);
      vecs[12] = mk(1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA2, 3'd3);
      vecs[13] = mk(1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA3, 3'd2);
      vecs[14] = mk(1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA4, 3'd1);
      vecs[15] = mk(1'b0, 1'b0, 32'h66, 1'b1, 1'b1, 1'b0, 32'h66, 3'd0);
      // 16-22: build count=2, then 5 cycles of simultaneous enqueue/dequeue
      vecs[16] = mk(1'b0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b1, 32'hB0, 3'd0);
      vecs[17] = mk(1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 32'hB0, 3'd1);
      vecs[18] = mk(1'b0, 1'b1, 32'hB2, 1'b1, 1'b1, 1'b1, 32'hB0, 3'd2);
      vecs[19] = mk(1'b0, 1'b1, 32'hB3, 1'b1, 1'b1, 1'b1, 32'hB1, 3'd2);
      vecs[20] = mk(1'b0, 1'b1, 32'hB4, 1'b1, 1'b1, 1'b1, 32'hB2, 3'd2);
      vecs[21] = mk(1'b0, 1'b1, 32'hB5, 1'b1, 1'b1, 1'b1, 32'hB3, 3'd2);
      vecs[22] = mk(1'b0, 1'b1, 32'hB6, 1'b1, 1'b1, 1'b1, 32'hB4, 3'd2);
      // 23-27: reach count=3, reset with handshake active, stale data must not reappear
      vecs[23] = mk(1'b0, 1'b1, 32'hB7, 1'b0, 1'b1, 1'b1, 32'hB5, 3'd2);
      vecs[24] = mk(1'b1, 1'b1, 32'hC0, 1'b1, 1'b1, 1'b1, 32'hB5, 3'd3);
      vecs[25] = mk(1'b0, 1'b1, 32'hC1, 1'b0, 1'b1, 1'b1, 32'hC1, 3'd0);
      vecs[26] = mk(1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hC1, 3'd1);
      vecs[27] = mk(1'b0, 1'b0, 32'h77, 1'b1, 1'b1, 1'b0, 32'h77, 3'd0);

      a_rst = 1'b1; a_iv = 1'b0; a_ins = '0; a_ordy = 1'b0;
      b_rst = 1'b1; b_iv = 1'b0; b_ins = '0; b_ordy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a_rst = 1'b0;
      b_rst = 1'b0;

      $display("[TB] directed vectors on 4-slot instance");
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d ins_ready", i), 32'(a_irdy), 32'(vecs[i].e_ready));
         checkOutput($sformatf("v%0d outs_valid", i), 32'(a_ovalid), 32'(vecs[i].e_valid));
         checkOutput($sformatf("v%0d outs", i), a_outs, vecs[i].e_outs);
         checkOutput($sformatf("v%0d count", i), 32'(a_count), 32'(vecs[i].e_count));
      end

      $display("[TB] randomized traffic on 3-slot instance");
      next_send  = 0;
      next_recv  = 0;
      stored_enq = 0;
      cycles     = 0;
      mq.delete();
      while (next_recv < 200 && cycles < 20000) begin
         int unsigned sz;
         logic e_ready, e_valid, acc, dq;
         logic [31:0] e_outs;
         @(negedge clk);
         if (!(b_iv && !(mq.size() < 3))) begin
            if (next_send < 200) begin
               b_iv  = ($urandom_range(0, 99) < 70);
               b_ins = next_send;
            end else begin
               b_iv  = 1'b0;
               b_ins = $urandom;
            end
         end
         b_ordy = ($urandom_range(0, 99) < 45);
         #1;
         sz      = mq.size();
         e_ready = (sz < 3);
         e_valid = b_iv | (sz > 0);
         e_outs  = (sz > 0) ? mq[0] : b_ins;
         checkOutput("rnd ins_ready", 32'(b_irdy), 32'(e_ready));
         checkOutput("rnd outs_valid", 32'(b_ovalid), 32'(e_valid));
         checkOutput("rnd count", 32'(b_count), sz);
         if (e_valid)
            checkOutput("rnd outs", b_outs, e_outs);
         acc = b_iv & e_ready;
         dq  = e_valid & b_ordy;
         if (dq) begin
            checkOutput("rnd order", b_outs, next_recv);
            next_recv++;
         end
         if (acc)
            next_send++;
         if (acc && !(sz == 0 && b_ordy)) begin
            mq.push_back(b_ins);
            stored_enq++;
         end
         if (sz > 0 && b_ordy)
            void'(mq.pop_front());
         cycles++;
      end
      if (next_recv < 200) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL rnd timeout: received %0d tokens, required 200", next_recv);
      end
      n_checks++;
      if (stored_enq < 30) begin
         n_fail++;
         $display("[TB] FAIL rnd wrap coverage: %0d stored enqueues, required >= 30", stored_enq);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tehb_fifo.md
Name: tehb_fifo

Overview:
- Parametrised, data-carrying successor of the single-slot dataless transparent elastic buffer.
- Provides NUM_SLOTS slots of DATA_TYPE-bit storage. Zero-latency bypass when empty. Strict FIFO order otherwise.
- Cuts the combinational ready path: ins_ready depends only on registered state, never on outs_ready.
- Placed on handshake channels to break long ready chains and absorb back-pressure bursts.

Parameters:
- DATA_TYPE, 32, data width in bits (>=1).
- NUM_SLOTS, 4, storage depth in entries (>=1, need not be a power of two).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ins  input  DATA_TYPE  input channel data.
- ins_valid  input  1  input channel valid.
- ins_ready  output  1  input channel ready.
- outs  output  DATA_TYPE  output channel data.
- outs_valid  output  1  output channel valid.
- outs_ready  input  1  output channel ready.
- count  output  $clog2(NUM_SLOTS+1)  current number of occupied slots (debug/monitor).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst: sampled only at the rising edge of clk.
- State: storage array mem[NUM_SLOTS], head pointer, tail pointer, occupancy counter cnt. Derived flags: empty = (cnt==0), full = (cnt==NUM_SLOTS).
- Reset: at a rising edge with rst=1, cnt, head and tail go to 0. mem is not cleared. rst overrides any handshake in the same cycle: no enqueue, no dequeue.
- Post-reset outputs:
  - ins_ready=1, count=0.
  - outs_valid=ins_valid and outs=ins, combinationally.
- Combinational outputs:
  - ins_ready = ~full.
  - outs_valid = ins_valid | ~empty.
  - outs = empty ? ins : mem[head].
  - count = cnt.
- Bypass (empty, ins_valid=1, outs_ready=1): the token passes through in the same cycle with zero latency. Nothing is stored. cnt is unchanged.
- Enqueue when ins_valid & ins_ready & ~(empty & outs_ready): write mem[tail] <= ins, then advance tail.
- Dequeue when ~empty & outs_ready: advance head.
- Simultaneous enqueue and dequeue (non-empty, not full): both happen and cnt is unchanged. Order is preserved: the new token goes to tail, and the head token is output.
- Full: ins_ready=0, so no enqueue. A dequeue the same cycle does NOT admit input that cycle; ins_ready rises the next cycle.
- Wrap-around: a pointer at NUM_SLOTS-1 advances to 0. An explicit compare is required, not power-of-two masking.
- cnt update per cycle: +1 on enqueue only, -1 on dequeue only, else hold. It never exceeds NUM_SLOTS and never drops below 0.
- Assertions: once outs_valid=1 with outs_ready=0, outs_valid must stay 1 and outs must stay stable next cycle. A token is never dropped or duplicated.
- NUM_SLOTS=1 must be cycle-equivalent in handshake to the single-slot dataless transparent buffer, with data added.
- No combinational path from outs_ready to ins_ready. Combinational paths ins_valid->outs_valid and ins->outs exist only through the bypass.

Test Plan:
1. Reset, then stream with outs_ready=1 held: ins=0x11,0x22,0x33 on consecutive cycles -> outs equals ins in the same cycle each time, count stays 0, ins_ready stays 1.
2. outs_ready=0, NUM_SLOTS=4: push 0xA0..0xA3 -> count climbs 1,2,3,4 and ins_ready drops to 0 after the 4th accept. A 5th value 0xA4 is held at the input, not accepted. outs=0xA0 with outs_valid=1 stable throughout.
3. From full, raise outs_ready=1 with ins_valid=1 (0xA4 held) -> cycle 0: outs=0xA0 and ins_ready=0. Next cycle: ins_ready=1 and 0xA4 is accepted. Drain order is 0xA0,0xA1,0xA2,0xA3,0xA4. count ends at 0.
4. Wrap-around with NUM_SLOTS=3: random ins_valid/outs_ready over 200 tokens, ins = incrementing counter -> output sequence strictly increments with no gaps. count always within 0..3. Both pointers wrap at least 10 times.
5. Simultaneous enqueue and dequeue with count=2: ins_valid=1, outs_ready=1 for 5 cycles -> count stays 2 and outputs stay in order.
6. Reset mid-operation: count=3, assert rst for 1 cycle with ins_valid=1 and outs_ready=1 -> after the edge, count=0 and ins_ready=1. The input token is not enqueued. outs_valid follows ins_valid, and the previously stored data never appears on outs.
